// File: rtl/inst_fetch_buffer_if.sv
// Handshake and program-load bundle between the fetch buffer and its users.
// master drives load/redirect/ready; slave (the buffer) drives the instruction head.
interface inst_fetch_buffer_if #(
    parameter int IW = 16,
    parameter int DW = 9
);
    logic          LoadEn;
    logic [IW-1:0] LoadAddr;
    logic [DW-1:0] LoadData;
    logic          Redirect;
    logic [IW-1:0] RedirectAddr;
    logic          InstReady;
    logic          InstValid;
    logic [DW-1:0] InstOut;
    logic [IW-1:0] InstPC;
    logic          Busy;

    modport master (
        output LoadEn, LoadAddr, LoadData,
        output Redirect, RedirectAddr, InstReady,
        input  InstValid, InstOut, InstPC, Busy
    );

    modport slave (
        input  LoadEn, LoadAddr, LoadData,
        input  Redirect, RedirectAddr, InstReady,
        output InstValid, InstOut, InstPC, Busy
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Writable instruction memory with registered read and a prefetch FIFO.
// Ports: CLK, Reset (sync, active-high), bus (slave: load, redirect, inst head).
module inst_fetch_buffer #(
    parameter int    IW        = 16,
    parameter int    DW        = 9,
    parameter int    FD        = 4,
    parameter string INIT_FILE = ""
) (
    input  logic              CLK,
    input  logic              Reset,
    inst_fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(FD);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [0:(1<<IW)-1];
    logic [DW-1:0] fifo_inst_q [FD];
    logic [IW-1:0] fifo_pc_q [FD];

    logic [IW-1:0] fetch_pc_q, fetch_pc_d;
    logic [DW-1:0] rd_data_q;
    logic [IW-1:0] rd_pc_q, rd_pc_d;
    logic          rd_valid_q, rd_valid_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] last_inst_q, last_inst_d;
    logic [IW-1:0] last_pc_q, last_pc_d;

    logic flush, issue, push, pop, not_empty;

    assign not_empty = (count_q != '0);
    assign flush     = bus.LoadEn | bus.Redirect;
    // Credit check uses pre-edge count: a same-cycle pop frees nothing.
    assign issue     = !flush &&
                       ((count_q + CW'(rd_valid_q)) < CW'(FD));
    assign push      = rd_valid_q && !flush;
    assign pop       = not_empty && bus.InstReady && !flush;

    assign bus.InstValid = not_empty;
    assign bus.InstOut   = not_empty ? fifo_inst_q[rd_ptr_q] : last_inst_q;
    assign bus.InstPC    = not_empty ? fifo_pc_q[rd_ptr_q] : last_pc_q;
    assign bus.Busy      = bus.LoadEn | !not_empty;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rd_pc_d     = rd_pc_q;
        rd_valid_d  = rd_valid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_inst_d = last_inst_q;
        last_pc_d   = last_pc_q;
        if (flush) begin
            fetch_pc_d = bus.LoadEn ? '0 : bus.RedirectAddr;
            rd_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            rd_valid_d = issue;
            if (issue) begin
                rd_pc_d    = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + IW'(1);
            end
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + AW'(1);
                last_inst_d = fifo_inst_q[rd_ptr_q];
                last_pc_d   = fifo_pc_q[rd_ptr_q];
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_pc_q  <= '0;
            rd_pc_q     <= '0;
            rd_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_inst_q <= '0;
            last_pc_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_pc_q     <= rd_pc_d;
            rd_valid_q  <= rd_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_inst_q <= last_inst_d;
            last_pc_q   <= last_pc_d;
        end
    end

    // Storage without reset: memory survives Reset, FIFO slots are
    // qualified by count.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (bus.LoadEn)
                mem_q[bus.LoadAddr] <= bus.LoadData;
            if (issue)
                rd_data_q <= mem_q[fetch_pc_q];
            if (push) begin
                fifo_inst_q[wr_ptr_q] <= rd_data_q;
                fifo_pc_q[wr_ptr_q]   <= rd_pc_q;
            end
            assert (!(push && !pop && count_q == CW'(FD)));
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized and directed bench for inst_fetch_buffer.
// Reference: sequential PC stream model with a sparse memory image.
module tb_inst_fetch_buffer;
    localparam int IW = 16;
    localparam int DW = 9;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    inst_fetch_buffer_if #(.IW(IW), .DW(DW)) bus ();

    inst_fetch_buffer #(.IW(IW), .DW(DW), .FD(4), .INIT_FILE("")) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl_mem [int];
    logic [IW-1:0] exp_pc;
    logic [IW-1:0] last_pc;
    logic [DW-1:0] last_inst;
    logic          last_known;
    int            since;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.LoadEn       = 1'b0;
        bus.LoadAddr     = '0;
        bus.LoadData     = '0;
        bus.Redirect     = 1'b0;
        bus.RedirectAddr = '0;
    endtask

    // One clock: check Busy, advance the model across the edge, then
    // check the head against the expected stream.
    task automatic cyc();
        bit vexp;
        @(negedge CLK);
        check("busy", 32'(bus.Busy), 32'(bus.LoadEn || since < 2));
        if (Reset) begin
            exp_pc = '0; last_pc = '0; last_inst = '0;
            last_known = 1'b1; since = 0;
        end else if (bus.LoadEn) begin
            mdl_mem[int'(bus.LoadAddr)] = bus.LoadData;
            exp_pc = '0; since = 0;
        end else if (bus.Redirect) begin
            exp_pc = bus.RedirectAddr; since = 0;
        end else begin
            if (since >= 2 && bus.InstReady) begin
                last_pc = exp_pc;
                last_known = mdl_mem.exists(int'(exp_pc));
                if (last_known) last_inst = mdl_mem[int'(exp_pc)];
                exp_pc = exp_pc + 1'b1;
            end
            if (since < 2) since++;
        end
        @(posedge CLK);
        #1;
        vexp = (since >= 2);
        check("valid", 32'(bus.InstValid), 32'(vexp));
        if (vexp) begin
            check("pc", 32'(bus.InstPC), 32'(exp_pc));
            if (mdl_mem.exists(int'(exp_pc)))
                check("inst", 32'(bus.InstOut), 32'(mdl_mem[int'(exp_pc)]));
        end else begin
            check("hold_pc", 32'(bus.InstPC), 32'(last_pc));
            if (last_known)
                check("hold_inst", 32'(bus.InstOut), 32'(last_inst));
        end
    endtask

    task automatic load(logic [IW-1:0] a, logic [DW-1:0] d);
        bus.LoadEn = 1'b1; bus.LoadAddr = a; bus.LoadData = d;
        cyc();
        bus.LoadEn = 1'b0;
    endtask

    task automatic redirect(logic [IW-1:0] a);
        bus.Redirect = 1'b1; bus.RedirectAddr = a;
        cyc();
        bus.Redirect = 1'b0;
    endtask

    task automatic run(int n, bit rdy);
        bus.InstReady = rdy;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        exp_pc = '0; last_pc = '0; last_inst = '0;
        last_known = 1'b1; since = 0;
        idle();
        bus.InstReady = 1'b0;
        Reset = 1'b1;
        run(2, 1'b0);
        check("rst_valid", 32'(bus.InstValid), 32'd0);
        check("rst_inst", 32'(bus.InstOut), 32'd0);
        check("rst_pc", 32'(bus.InstPC), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd1);
        Reset = 1'b0;

        for (int i = 0; i < 64; i++)
            load(IW'(i), (i < 6) ? DW'(i + 1) : DW'($urandom));
        load(16'hFFFE, 9'h0AB);
        load(16'hFFFF, 9'h0CD);

        // Memory must survive reset; stream restarts from 0.
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        run(6, 1'b1);

        // Backpressure, then drain with no gaps.
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        run(10, 1'b0);
        run(8, 1'b1);

        // Redirect with a partly consumed FIFO and a read in flight.
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        run(2, 1'b0);
        run(2, 1'b1);
        bus.InstReady = 1'b0;
        redirect(16'h0040);
        run(2, 1'b0);
        run(4, 1'b1);

        // Address wrap at the top of memory.
        bus.InstReady = 1'b1;
        redirect(16'hFFFE);
        run(6, 1'b1);

        // Program load mid-stream.
        load(16'h0000, 9'h1AA);
        load(16'h0001, 9'h155);
        load(16'h0002, 9'h0F0);
        run(5, 1'b1);

        // Reset dominates a coincident load and redirect.
        Reset = 1'b1;
        bus.LoadEn = 1'b1; bus.LoadAddr = '0; bus.LoadData = 9'h1FF;
        bus.Redirect = 1'b1; bus.RedirectAddr = 16'h0020;
        cyc();
        Reset = 1'b0;
        idle();
        run(4, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            int r;
            idle();
            Reset = 1'b0;
            bus.InstReady = 1'($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                Reset = 1'b1;
            end else if (r < 6) begin
                bus.LoadEn = 1'b1;
                bus.LoadAddr = IW'($urandom_range(0, 80));
                bus.LoadData = DW'($urandom);
                bus.Redirect = 1'($urandom);
                bus.RedirectAddr = IW'($urandom);
            end else if (r < 16) begin
                bus.Redirect = 1'b1;
                bus.RedirectAddr = ($urandom_range(0, 3) == 0) ?
                    IW'(16'hFFF8 + $urandom_range(0, 7)) :
                    IW'($urandom_range(0, 63));
            end
            cyc();
        end
        idle();
        Reset = 1'b0;
        run(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
